// File: rtl/rib_timer.sv
// rib_timer: memory-mapped RIB timer peripheral.
//
// Register map (addr_i[3:0]):
//   0x0 CTRL    bit0 EN, bit1 INT_EN, bit2 PEND (write-1-to-clear), bit3 RELOAD
//   0x4 COUNT   free-running up counter compared against COMPARE
//   0x8 COMPARE match value
//   0xC PRESC   8-bit tick prescaler (only when RIB_TIMER_PRESCALER_EN is defined)
//
// Optional feature: define RIB_TIMER_PRESCALER_EN to add the PRESC register
// and the prescale counter. Without it every clock cycle is a tick and
// offset 0xC behaves as an unmapped location.
//
// Bus writes always take priority over hardware updates of COUNT and EN,
// while a match setting PEND wins over a simultaneous write-1-to-clear.

module rib_timer #(
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  localparam logic [3:0] OFF_CTRL    = 4'h0;
  localparam logic [3:0] OFF_COUNT   = 4'h4;
  localparam logic [3:0] OFF_COMPARE = 4'h8;
`ifdef RIB_TIMER_PRESCALER_EN
  localparam logic [3:0] OFF_PRESC   = 4'hC;
`endif

  // Architectural state
  logic        en_q;
  logic        int_en_q;
  logic        pend_q;
  logic        reload_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;

  // Bus decode
  logic [3:0]  offset;
  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_compare;

  // Counting control
  logic        tick;
  logic        match;
  logic        advance;

  // Upper address bits are deliberately not decoded, so the block aliases
  // every 16 bytes.
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr_i[31:4];

  assign offset     = addr_i[3:0];
  assign wr_en      = req_i & we_i;
  assign wr_ctrl    = wr_en && (offset == OFF_CTRL);
  assign wr_count   = wr_en && (offset == OFF_COUNT);
  assign wr_compare = wr_en && (offset == OFF_COMPARE);

`ifdef RIB_TIMER_PRESCALER_EN
  logic [7:0] presc_q;
  logic [7:0] psc_cnt_q;
  logic       wr_presc;

  assign wr_presc = wr_en && (offset == OFF_PRESC);
  assign tick     = en_q && (psc_cnt_q == presc_q);

  // PRESC register: plain 8-bit read/write value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= 8'd0;
    end else if (wr_presc) begin
      presc_q <= data_i[7:0];
    end
  end

  // Prescale counter: runs only while enabled and restarts after every tick
  // (a match is always on a tick, so it restarts the prescaler as well)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt_q <= 8'd0;
    end else if (!en_q || tick) begin
      psc_cnt_q <= 8'd0;
    end else begin
      psc_cnt_q <= psc_cnt_q + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Match uses the pre-edge COUNT/COMPARE, so a write in the same cycle
  // cannot hide or fake a match.
  assign match   = tick && en_q && (count_q == compare_q);
  assign advance = tick && en_q && !match;

  // COUNT: software write wins, then reload-on-match, then increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 32'd0;
    end else if (wr_count) begin
      count_q <= data_i;
    end else if (match) begin
      if (reload_q) begin
        count_q <= 32'd0;
      end
    end else if (advance) begin
      count_q <= count_q + 32'd1;
    end
  end

  // COMPARE: plain read/write register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= COMPARE_RST;
    end else if (wr_compare) begin
      compare_q <= data_i;
    end
  end

  // EN: software write wins over the one-shot auto-disable on match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0;
    end else if (wr_ctrl) begin
      en_q <= data_i[0];
    end else if (match && !reload_q) begin
      en_q <= 1'b0;
    end
  end

  // INT_EN and RELOAD: plain control bits written through CTRL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_en_q <= 1'b0;
      reload_q <= 1'b0;
    end else if (wr_ctrl) begin
      int_en_q <= data_i[1];
      reload_q <= data_i[3];
    end
  end

  // PEND: set by a match, cleared by writing 1 to CTRL bit2; set wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else if (match) begin
      pend_q <= 1'b1;
    end else if (wr_ctrl && data_i[2]) begin
      pend_q <= 1'b0;
    end
  end

  // Interrupt depends only on registered state, never on the bus inputs
  assign int_sig_o = pend_q & int_en_q;

  // Read mux: same-cycle read data, zero when no request is active
  always_comb begin
    data_o = 32'd0;
    if (req_i) begin
      case (offset)
        OFF_CTRL:    data_o = {28'd0, reload_q, pend_q, int_en_q, en_q};
        OFF_COUNT:   data_o = count_q;
        OFF_COMPARE: data_o = compare_q;
`ifdef RIB_TIMER_PRESCALER_EN
        OFF_PRESC:   data_o = {24'd0, presc_q};
`endif
        default:     data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_timer.sv
// tb_rib_timer: self-checking bench for rib_timer.
// Table-driven vectors, directed multi-cycle sequences and a randomized
// phase checked against a register-level reference model.
// Follows RIB_TIMER_PRESCALER_EN the same way the design does.

module tb_rib_timer;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        int_sig_o;

  int errors = 0;
  int checks = 0;

  rib_timer dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .int_sig_o (int_sig_o)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_int;
  } vec_t;

  vec_t vecs[15];

  // Reference model: register contents as software sees them
  logic        m_en, m_int_en, m_pend, m_reload;
  logic [31:0] m_count, m_compare;
  logic [7:0]  m_presc, m_pcnt;

  function automatic void model_reset();
    m_en = 0; m_int_en = 0; m_pend = 0; m_reload = 0;
    m_count = 0; m_compare = 32'hFFFF_FFFF;
    m_presc = 0; m_pcnt = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic req, input logic [31:0] addr);
    if (!req) return 32'd0;
    case (addr[3:0])
      4'h0: return {28'd0, m_reload, m_pend, m_int_en, m_en};
      4'h4: return m_count;
      4'h8: return m_compare;
`ifdef RIB_TIMER_PRESCALER_EN
      4'hC: return {24'd0, m_presc};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer, expressed in terms of register behaviour
  function automatic void model_step(input logic req, input logic we,
                                     input logic [31:0] addr, input logic [31:0] data);
    logic        wr;
    logic        is_tick;
    logic        hit;
    logic [31:0] n_count;
    logic        n_en, n_pend;
    logic [7:0]  n_pcnt;
    wr = req && we;
`ifdef RIB_TIMER_PRESCALER_EN
    is_tick = m_en && (m_pcnt == m_presc);
    n_pcnt  = (!m_en || is_tick) ? 8'd0 : m_pcnt + 8'd1;
`else
    is_tick = 1'b1;
    n_pcnt  = 8'd0;
`endif
    hit = m_en && is_tick && (m_count == m_compare);
    n_count = m_count;
    n_en    = m_en;
    n_pend  = m_pend;
    if (hit) begin
      n_pend = 1;
      if (m_reload) n_count = 0;
      else n_en = 0;
    end else if (m_en && is_tick) begin
      n_count = m_count + 1;
    end
    if (wr) begin
      case (addr[3:0])
        4'h0: begin
          n_en = data[0];
          m_int_en = data[1];
          m_reload = data[3];
          if (data[2] && !hit) n_pend = 0;
        end
        4'h4: n_count = data;
        4'h8: m_compare = data;
`ifdef RIB_TIMER_PRESCALER_EN
        4'hC: m_presc = data[7:0];
`endif
        default: ;
      endcase
    end
    m_count = n_count;
    m_en    = n_en;
    m_pend  = n_pend;
    m_pcnt  = n_pcnt;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    req_i = 0; we_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    req_i = 1; we_i = 1; addr_i = addr; data_i = data;
    @(posedge clk); #1;
    req_i = 0; we_i = 0;
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] val);
    req_i = 1; we_i = 0; addr_i = addr;
    #1;
    val = data_o;
    req_i = 0;
  endtask

  task automatic peek_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    peek(addr, v);
    check(name, v, exp);
  endtask

  task automatic do_reset();
    rst = 1; req_i = 0; we_i = 0; addr_i = 0; data_i = 0;
    @(posedge clk); #1;
    rst = 0;
    #1;
    model_reset();
  endtask

  // Wait (bounded) until COUNT reads the target; the next edge then acts on it
  task automatic wait_count(input logic [31:0] target, input int budget);
    logic [31:0] v;
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      peek(32'h4, v);
      if (v == target) begin
        found = 1;
        break;
      end
      idle();
    end
    if (!found) check("wait_count timeout", v, target);
  endtask

  // Drive one random bus cycle
  task automatic applyStimulus(output logic r, output logic w,
                               output logic [31:0] a, output logic [31:0] d);
    int sel;
    r = ($urandom_range(0, 3) != 0);
    w = r && ($urandom_range(0, 5) == 0);
    sel = $urandom_range(0, 4);
    case (sel)
      0: a = 32'h0;
      1: a = 32'h4;
      2: a = 32'h8;
      3: a = 32'hC;
      default: a = $urandom();
    endcase
    case (a[3:0])
      4'h0: d = {$urandom_range(0, 255), 4'h0} | 32'($urandom_range(0, 15));
      4'h4, 4'h8: d = 32'($urandom_range(0, 12));
      4'hC: d = {$urandom_range(0, 255), 8'h0} | 32'($urandom_range(0, 3));
      default: d = $urandom();
    endcase
    req_i = r; we_i = w; addr_i = a; data_i = d;
  endtask

  // Compare the current outputs against the model before the edge
  task automatic checkOutput(input logic r, input logic [31:0] a);
    check("rand data_o", data_o, model_read(r, a));
    check("rand int_sig_o", {31'd0, int_sig_o}, {31'd0, m_pend & m_int_en});
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] ed, input logic ei);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.data = d; v.exp_data = ed; v.exp_int = ei;
    return v;
  endfunction

  initial begin
    logic [31:0] v;
    logic r, w;
    logic [31:0] a, d;

    // Periodic reload table: COMPARE=5, CTRL=0xB, then a W1C of PEND
    vecs[0]  = mk(1, 0, 32'h8, 0,      32'hFFFF_FFFF, 0);
    vecs[1]  = mk(1, 1, 32'h8, 5,      32'hFFFF_FFFF, 0);
    vecs[2]  = mk(1, 1, 32'h0, 32'hB,  32'h0, 0);
    vecs[3]  = mk(1, 0, 32'h4, 0,      32'd0, 0);
    vecs[4]  = mk(1, 0, 32'h4, 0,      32'd1, 0);
    vecs[5]  = mk(1, 0, 32'h4, 0,      32'd2, 0);
    vecs[6]  = mk(1, 0, 32'h4, 0,      32'd3, 0);
    vecs[7]  = mk(1, 0, 32'h4, 0,      32'd4, 0);
    vecs[8]  = mk(1, 0, 32'h4, 0,      32'd5, 0);
    vecs[9]  = mk(1, 0, 32'h0, 0,      32'hF, 1);
    vecs[10] = mk(1, 0, 32'h4, 0,      32'd1, 1);
    vecs[11] = mk(1, 1, 32'h0, 32'hF,  32'hF, 1);
    vecs[12] = mk(1, 0, 32'h0, 0,      32'hB, 0);
    vecs[13] = mk(1, 0, 32'h2, 0,      32'h0, 0);
    vecs[14] = mk(0, 0, 32'h4, 0,      32'h0, 0);

    rst = 1; req_i = 0; we_i = 0; addr_i = 0; data_i = 0;
    #2;
    // Reset values while rst is held
    peek_check("reset CTRL", 32'h0, 32'h0);
    peek_check("reset COUNT", 32'h4, 32'h0);
    peek_check("reset COMPARE", 32'h8, 32'hFFFF_FFFF);
    check("reset int", {31'd0, int_sig_o}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 15; i++) begin
      req_i = vecs[i].req; we_i = vecs[i].we; addr_i = vecs[i].addr; data_i = vecs[i].data;
      #1;
      check($sformatf("vec%0d data_o", i), data_o, vecs[i].exp_data);
      check($sformatf("vec%0d int", i), {31'd0, int_sig_o}, {31'd0, vecs[i].exp_int});
      @(posedge clk); #1;
    end
    req_i = 0; we_i = 0;

    $display("[TB] one-shot");
    do_reset();
    do_write(32'h8, 3);
    do_write(32'h0, 32'h3);
    wait_count(3, 20);
    idle();
    peek_check("oneshot CTRL", 32'h0, 32'h6);
    for (int i = 0; i < 3; i++) begin
      peek_check("oneshot COUNT hold", 32'h4, 32'd3);
      check("oneshot int held", {31'd0, int_sig_o}, 32'd1);
      idle();
    end
    do_write(32'h0, 32'h4);
    check("oneshot int cleared", {31'd0, int_sig_o}, 32'd0);
    peek_check("oneshot CTRL cleared", 32'h0, 32'h0);

    $display("[TB] wrap");
    do_reset();
    do_write(32'h4, 32'hFFFF_FFFE);
    do_write(32'h8, 1);
    do_write(32'h0, 32'h1);
    peek_check("wrap start", 32'h4, 32'hFFFF_FFFE);
    idle();
    peek_check("wrap max", 32'h4, 32'hFFFF_FFFF);
    idle();
    peek_check("wrap zero", 32'h4, 32'h0);
    idle();
    peek_check("wrap one", 32'h4, 32'h1);
    idle();
    peek_check("wrap CTRL pend", 32'h0, 32'h4);
    peek_check("wrap COUNT hold", 32'h4, 32'h1);
    check("wrap int off", {31'd0, int_sig_o}, 32'd0);

    $display("[TB] collisions");
    do_reset();
    do_write(32'h8, 3);
    do_write(32'h0, 32'hB);
    wait_count(3, 20);
    idle();
    peek_check("coll first pend", 32'h0, 32'hF);
    wait_count(3, 20);
    do_write(32'h0, 32'hF);
    peek_check("coll W1C vs match", 32'h0, 32'hF);
    do_write(32'h0, 32'hF);
    peek_check("coll W1C clears", 32'h0, 32'hB);
    wait_count(3, 20);
    do_write(32'h4, 100);
    peek_check("coll COUNT write wins", 32'h4, 32'd100);
    peek_check("coll pend on match", 32'h0, 32'hF);

    $display("[TB] reset mid-operation");
    do_reset();
    do_write(32'h8, 2);
    do_write(32'h0, 32'hB);
    for (int i = 0; i < 4; i++) idle();
    check("midrst int before", {31'd0, int_sig_o}, 32'd1);
    rst = 1;
    #1;
    check("midrst int", {31'd0, int_sig_o}, 32'd0);
    peek_check("midrst COUNT", 32'h4, 32'h0);
    peek_check("midrst CTRL", 32'h0, 32'h0);
    peek_check("midrst COMPARE", 32'h8, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rst = 0;
    #1;
    model_reset();

`ifdef RIB_TIMER_PRESCALER_EN
    $display("[TB] prescaler");
    do_write(32'hC, 2);
    peek_check("presc readback", 32'hC, 32'h2);
    do_write(32'h8, 2);
    do_write(32'h0, 32'h3);
    for (int k = 1; k <= 8; k++) begin
      idle();
      peek_check($sformatf("presc count k=%0d", k), 32'h4, 32'(k / 3));
      peek_check($sformatf("presc nopend k=%0d", k), 32'h0, 32'h3);
    end
    idle();
    peek_check("presc pend", 32'h0, 32'h6);
`else
    $display("[TB] unmapped 0xC");
    do_write(32'hC, 32'hFF);
    peek_check("offset C reads 0", 32'hC, 32'h0);
`endif

    $display("[TB] random vs model");
    do_reset();
    for (int n = 0; n < 800; n++) begin
      applyStimulus(r, w, a, d);
      #1;
      checkOutput(r, a);
      @(posedge clk);
      model_step(r, w, a, d);
      #1;
    end
    req_i = 0; we_i = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
